// File: rtl/inertial_pkg.sv
// Shared types and command words for the inertial sensor front end.
package inertial_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;

  typedef enum logic [1:0] {SPI_IDLE, SPI_FRONT, SPI_SHIFT, SPI_BACK} spi_state_t;

  localparam logic [15:0] CFG_INT   = 16'h0D02;
  localparam logic [15:0] CFG_ACC   = 16'h1053;
  localparam logic [15:0] CFG_GYR   = 16'h1150;
  localparam logic [15:0] CFG_RND   = 16'h1460;
  localparam logic [15:0] RD_PL_CMD = 16'hA200;
  localparam logic [15:0] RD_PH_CMD = 16'hA300;
  localparam logic [15:0] RD_AL_CMD = 16'hAC00;
  localparam logic [15:0] RD_AH_CMD = 16'hAD00;

  // Word sent on entry to each frame-issuing state.
  function automatic logic [15:0] cmd_for(state_t s);
    case (s)
      CFG0:    return CFG_INT;
      CFG1:    return CFG_ACC;
      CFG2:    return CFG_GYR;
      CFG3:    return CFG_RND;
      RD_PL:   return RD_PL_CMD;
      RD_PH:   return RD_PH_CMD;
      RD_AL:   return RD_AL_CMD;
      RD_AH:   return RD_AH_CMD;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/inertial_interface_spi.sv
// Generic 16-bit mode-3 SPI master: SCLK idle high, MOSI changes on fall, MISO sampled on rise.
module spi_mnrch
  import inertial_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  spi_state_t              st;
  logic [SCLK_DIV_W-2:0]   cnt;
  logic [4:0]              rises;
  logic [15:0]             shft;
  logic                    smpl;
  logic                    half_end;

  assign half_end = &cnt;
  assign MOSI     = shft[15];
  assign rd_data  = shft;

  // Outgoing bits leave the top of shft while sampled bits enter at the bottom;
  // the final sample is folded in when SS_n rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= SPI_IDLE;
      cnt   <= '0;
      rises <= '0;
      shft  <= '0;
      smpl  <= 1'b0;
      SS_n  <= 1'b1;
      SCLK  <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        SPI_IDLE: if (wrt) begin
          SS_n  <= 1'b0;
          shft  <= wt_data;
          cnt   <= '0;
          rises <= '0;
          st    <= SPI_FRONT;
        end
        SPI_FRONT: begin
          cnt <= cnt + 1'b1;
          if (half_end) begin
            SCLK <= 1'b0;
            st   <= SPI_SHIFT;
          end
        end
        SPI_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (half_end) begin
            if (!SCLK) begin
              SCLK  <= 1'b1;
              smpl  <= MISO;
              rises <= rises + 1'b1;
              if (rises == 5'd15) st <= SPI_BACK;
            end else begin
              SCLK <= 1'b0;
              shft <= {shft[14:0], smpl};
            end
          end
        end
        SPI_BACK: begin
          cnt <= cnt + 1'b1;
          if (half_end) begin
            SS_n <= 1'b1;
            shft <= {shft[14:0], smpl};
            done <= 1'b1;
            st   <= SPI_IDLE;
          end
        end
        default: st <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/inertial_interface.sv
// Inertial sensor producer: powers up, configures over SPI, then reads pitch rate and Z accel per INT.
module inertial_interface
  import inertial_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int INIT_CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  state_t                state;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic                  int_ff1, int_ff2;
  logic                  wrt, done;
  logic [15:0]           wt_data, rd_data;
  logic [7:0]            pl, ph, al;
  logic                  unused_hi;

  assign unused_hi = ^rd_data[15:8];

  spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) {int_ff1, int_ff2} <= 2'b00;
    else        {int_ff1, int_ff2} <= {INT, int_ff1};
  end

  // Every frame-issuing transition loads the next command and pulses wrt together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      init_cnt <= '0;
      wrt      <= 1'b0;
      wt_data  <= '0;
      pl       <= '0;
      ph       <= '0;
      al       <= '0;
      vld      <= 1'b0;
      ptch_rt  <= '0;
      AZ       <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        INIT_WAIT:
          if (&init_cnt) begin
            state <= CFG0; wrt <= 1'b1; wt_data <= cmd_for(CFG0);
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        CFG0: if (done) begin state <= CFG1; wrt <= 1'b1; wt_data <= cmd_for(CFG1); end
        CFG1: if (done) begin state <= CFG2; wrt <= 1'b1; wt_data <= cmd_for(CFG2); end
        CFG2: if (done) begin state <= CFG3; wrt <= 1'b1; wt_data <= cmd_for(CFG3); end
        CFG3: if (done) state <= WAIT_INT;
        WAIT_INT:
          if (int_ff2) begin state <= RD_PL; wrt <= 1'b1; wt_data <= cmd_for(RD_PL); end
        RD_PL: if (done) begin
          pl <= rd_data[7:0]; state <= RD_PH; wrt <= 1'b1; wt_data <= cmd_for(RD_PH);
        end
        RD_PH: if (done) begin
          ph <= rd_data[7:0]; state <= RD_AL; wrt <= 1'b1; wt_data <= cmd_for(RD_AL);
        end
        RD_AL: if (done) begin
          al <= rd_data[7:0]; state <= RD_AH; wrt <= 1'b1; wt_data <= cmd_for(RD_AH);
        end
        RD_AH: if (done) begin
          ptch_rt <= {ph, pl};
          AZ      <= {rd_data[7:0], al};
          vld     <= 1'b1;
          state   <= WAIT_INT;
        end
        default: state <= INIT_WAIT;
      endcase
    end
  end

endmodule
